// File: rtl/conv2d_layer_sequencer.sv
// Steps one shared Conv2d engine through NUM_LAYERS layers per run command.
// Optional watchdog on the per-layer wait is enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv2d_layer_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int LAYER_W        = 3,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               abort,
    output logic               conv_start,
    input  logic               conv_finish,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   total_cycles
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER  = LAYER_W'(NUM_LAYERS - 1);

    if (NUM_LAYERS < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        (NUM_LAYERS - 1) >= (1 << LAYER_W)) begin : g_bad_params
        $error("conv2d_layer_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic               finish_q;
    logic               conv_start_q, busy_q, done_q;
    logic               conv_start_d, busy_d, done_d;
    logic               finish_event;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    assign finish_event = conv_finish & ~finish_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        layer_d  = layer_q;
        total_d  = total_q;
`ifdef CONV_SEQ_TIMEOUT_EN
        wd_d     = wd_q;
        error_d  = error_q;
`endif
        if (busy_q && (total_q != {CNT_W{1'b1}})) begin
            total_d = total_q + 1'b1;
        end

        // Abort wins over everything else, leaving error and the cycle count intact.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            layer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run && !abort) begin
                        state_d  = SETTLE;
                        settle_d = '0;
                        layer_d  = '0;
                        total_d  = '0;
`ifdef CONV_SEQ_TIMEOUT_EN
                        error_d  = 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = START;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                START: begin
                    state_d = WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
                    wd_d    = WD_W'(1);
`endif
                end
                WAIT: begin
                    if (finish_event) begin
                        if (layer_q == LAST_LAYER) begin
                            state_d = DONE;
                        end else begin
                            state_d  = SETTLE;
                            settle_d = '0;
                            layer_d  = layer_q + 1'b1;
                        end
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else if (wd_q >= WD_LAST) begin
                        state_d = IDLE;
                        layer_d = '0;
                        error_d = 1'b1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_d = IDLE;
                    layer_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    layer_d = '0;
                end
            endcase
        end

        // Outputs are registered, so they are decoded from the upcoming state.
        conv_start_d = (state_d == START);
        busy_d       = (state_d == SETTLE) || (state_d == START) || (state_d == WAIT);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            layer_q      <= '0;
            total_q      <= '0;
            finish_q     <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            wd_q         <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            layer_q      <= layer_d;
            total_q      <= total_d;
            finish_q     <= conv_finish;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CONV_SEQ_TIMEOUT_EN
            wd_q         <= wd_d;
            error_q      <= error_d;
`endif
        end
    end

    assign conv_start   = conv_start_q;
    assign layer_idx    = layer_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign total_cycles = total_q;
`ifdef CONV_SEQ_TIMEOUT_EN
    assign error        = error_q;
`else
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_conv2d_layer_sequencer.sv
// Scoreboard bench for conv2d_layer_sequencer: expected start/done events are queued
// when a run is launched and checked when the sequencer emits them.
module tb_conv2d_layer_sequencer;

   localparam int N   = 4;
   localparam int S   = 2;
   localparam int L   = 10;
   localparam int TMO = 20;
   localparam int LW  = 3;
   localparam int CW  = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          run;
   logic          abort;
   logic          conv_finish = 1'b0;
   logic          conv_start;
   logic [LW-1:0] layer_idx;
   logic          busy;
   logic          done;
   logic          error;
   logic [CW-1:0] total_cycles;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   bit   model_level = 1'b0;
   bit   model_hang = 1'b0;
   int   next_rise = -1;
   int   drop_at = -1;
   logic fin_level = 1'b0;

   typedef struct {
      int cyc;
      int layer;
   } start_exp_t;

   typedef struct {
      int cyc;
      int total;
   } done_exp_t;

   start_exp_t start_q[$];
   done_exp_t  done_q[$];

   conv2d_layer_sequencer #(
      .NUM_LAYERS(N),
      .LAYER_W(LW),
      .SETTLE_CYCLES(S),
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .run(run),
      .abort(abort),
      .conv_start(conv_start),
      .conv_finish(conv_finish),
      .layer_idx(layer_idx),
      .busy(busy),
      .done(done),
      .error(error),
      .total_cycles(total_cycles)
   );

   always #5 clk = ~clk;

   // Free-running cycle number; read #1 after a rising edge it names the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic runVal, input logic abortVal);
      run = runVal;
      abort = abortVal;
   endtask

   task automatic gotoCycle(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the start pulses (and optionally the done pulse) of a run whose cycle 0 is t0.
   function automatic void pushRun(input int t0, input int nStarts, input bit withDone);
      for (int j = 0; j < nStarts; j++) begin
         start_q.push_back('{t0 + S + 1 + j * (L + S + 1), j});
      end
      if (withDone) begin
         done_q.push_back('{t0 + N * (S + 1 + L) + 1, N * (S + 1 + L)});
      end
   endfunction

   // Conv2d engine model: finish edge seen L cycles after each start pulse.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && conv_start === 1'b1 && !model_hang) begin
         next_rise = cyc + L;
         drop_at = cyc + 1;
      end
   end

   // Pulse mode raises finish for one cycle; level mode holds it until just after the next start.
   always @(posedge clk) begin
      #1;
      if (model_level) begin
         if (cyc == drop_at) fin_level = 1'b0;
         if (cyc == next_rise) fin_level = 1'b1;
         conv_finish = fin_level;
      end else begin
         conv_finish = (cyc == next_rise);
      end
   end

   // Scoreboard side: every start/done pulse must match the head of its queue.
   always @(negedge clk) begin : monitor
      start_exp_t se;
      done_exp_t  de;
      if (rst_n === 1'b1) begin
         if (conv_start !== 1'b0) begin
            if (start_q.size() == 0) begin
               checkOutput("unexpected_start", conv_start, 0);
            end else begin
               se = start_q.pop_front();
               checkOutput("start_cycle", cyc, se.cyc);
               checkOutput("start_layer", layer_idx, se.layer);
            end
         end
         if (done !== 1'b0) begin
            if (done_q.size() == 0) begin
               checkOutput("unexpected_done", done, 0);
            end else begin
               de = done_q.pop_front();
               checkOutput("done_cycle", cyc, de.cyc);
               checkOutput("done_total", total_cycles, de.total);
               checkOutput("done_busy", busy, 0);
            end
         end
      end
   end

   initial begin : main
      int t0;
      int t1;
      int r;

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_conv_start", conv_start, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_layer", layer_idx, 0);
      checkOutput("rst_total", total_cycles, 0);
      rst_n = 1'b1;
      gotoCycle(cyc + 2);

      $display("[TB] basic run, pulsed finish");
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, N, 1'b1);
      checkOutput("t1_busy_c0", busy, 0);
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t1_busy_c1", busy, 1);
      checkOutput("t1_layer_c1", layer_idx, 0);
      gotoCycle(t0 + 54);
      checkOutput("t1_idle_busy", busy, 0);
      checkOutput("t1_idle_layer", layer_idx, 0);
      checkOutput("t1_idle_total", total_cycles, N * (S + 1 + L));
      checkOutput("t1_idle_error", error, 0);
      gotoCycle(cyc + 3);

      $display("[TB] finish held as a level across layers");
      model_level = 1'b1;
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, N, 1'b1);
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      gotoCycle(t0 + 54);
      checkOutput("t2_idle_busy", busy, 0);
      checkOutput("t2_idle_total", total_cycles, N * (S + 1 + L));
      model_level = 1'b0;
      gotoCycle(cyc + 3);

      $display("[TB] abort during layer 2 wait, same cycle as finish edge");
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, 3, 1'b0);
      r = t0 + S + 1 + 2 * (L + S + 1) + L;
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      gotoCycle(r);
      checkOutput("t3_layer_pre", layer_idx, 2);
      applyStimulus(1'b0, 1'b1);
      gotoCycle(r + 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t3_busy", busy, 0);
      checkOutput("t3_layer", layer_idx, 0);
      checkOutput("t3_total", total_cycles, r - t0);
      checkOutput("t3_done", done, 0);
      gotoCycle(r + 6);
      checkOutput("t3_total_frozen", total_cycles, r - t0);
      checkOutput("t3_busy_later", busy, 0);

      $display("[TB] async reset during settle of layer 1");
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, 1, 1'b0);
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      gotoCycle(t0 + S + 1 + L + 1 + 1);
      checkOutput("t4_layer_pre", layer_idx, 1);
      checkOutput("t4_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t4_conv_start", conv_start, 0);
      checkOutput("t4_busy", busy, 0);
      checkOutput("t4_done", done, 0);
      checkOutput("t4_error", error, 0);
      checkOutput("t4_layer", layer_idx, 0);
      checkOutput("t4_total", total_cycles, 0);
      gotoCycle(cyc + 2);
      rst_n = 1'b1;
      gotoCycle(cyc + 1);
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, N, 1'b1);
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t4b_layer_c1", layer_idx, 0);
      gotoCycle(t0 + 54);
      checkOutput("t4b_total", total_cycles, N * (S + 1 + L));
      gotoCycle(cyc + 2);

      $display("[TB] run while busy, then run held high");
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, N, 1'b1);
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      gotoCycle(t0 + 20);
      applyStimulus(1'b1, 1'b0);
      gotoCycle(t0 + 21);
      applyStimulus(1'b0, 1'b0);
      gotoCycle(t0 + 45);
      applyStimulus(1'b1, 1'b0);
      t1 = t0 + N * (S + 1 + L) + 2;
      pushRun(t1, N, 1'b1);
      gotoCycle(t1);
      checkOutput("t5_idle_between", busy, 0);
      gotoCycle(t1 + 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t5_second_busy", busy, 1);
      checkOutput("t5_second_total", total_cycles, 0);
      gotoCycle(t1 + 54);
      checkOutput("t5_end_busy", busy, 0);
      checkOutput("t5_end_total", total_cycles, N * (S + 1 + L));
      gotoCycle(cyc + 2);

`ifdef CONV_SEQ_TIMEOUT_EN
      $display("[TB] watchdog with a hung engine");
      model_hang = 1'b1;
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, 1, 1'b0);
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      gotoCycle(t0 + S + 1 + TMO - 1);
      checkOutput("t6_error_early", error, 0);
      checkOutput("t6_busy_early", busy, 1);
      gotoCycle(t0 + S + 1 + TMO);
      checkOutput("t6_error", error, 1);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_layer", layer_idx, 0);
      checkOutput("t6_total", total_cycles, S + TMO);
      gotoCycle(cyc + 2);
      checkOutput("t6_error_sticky", error, 1);
      model_hang = 1'b0;
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      pushRun(t0, N, 1'b1);
      gotoCycle(t0 + 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t6_error_cleared", error, 0);
      gotoCycle(t0 + 54);
      checkOutput("t6_rerun_error", error, 0);
`endif

      gotoCycle(cyc + 3);
      checkOutput("start_queue_empty", start_q.size(), 0);
      checkOutput("done_queue_empty", done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/conv2d_layer_sequencer.md
# conv2d_layer_sequencer

Sequences a single shared Conv2d engine through `NUM_LAYERS` consecutive layers of the inference pipeline. On `run` it:
- presents each layer index to the weight/bias/feature-map selection muxes and lets it settle;
- pulses the engine's `start`, then waits for the engine's `finish`.

It reports overall completion, elapsed cycles and (optionally) a watchdog error. It sits between the top-level model controller and the Conv2d instance.

## Interface
Parameters:
- `NUM_LAYERS`, 4, number of layers run per `run` command (≥1)
- `LAYER_W`, 3, width of `layer_idx`; must represent `NUM_LAYERS-1`
- `SETTLE_CYCLES`, 2, cycles `layer_idx` is held stable before `conv_start` (≥1)
- `TIMEOUT_CYCLES`, 65535, watchdog limit per layer, counted in WAIT
- `CNT_W`, 32, width of `total_cycles`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  start request; sampled only in IDLE
- `abort`  in  1  synchronous abort; effective in any non-IDLE state
- `conv_start`  out  1  one-cycle start pulse to Conv2d
- `conv_finish`  in  1  Conv2d finish; only a rising edge is significant
- `layer_idx`  out  `LAYER_W`  current layer; drives weight/bias/data muxes
- `busy`  out  1  high from the cycle after `run` acceptance until DONE/IDLE
- `done`  out  1  one-cycle pulse after the last layer's finish
- `error`  out  1  sticky watchdog flag; cleared on `run` acceptance
- `total_cycles`  out  `CNT_W`  number of busy cycles in the last/current run

## Operation
- All outputs are registered. Reset values: `conv_start`=0, `layer_idx`=0, `busy`=0, `done`=0, `error`=0, `total_cycles`=0. State resets to IDLE and `finish_q`=0.
- `finish_q` samples `conv_finish` every cycle. A finish event is `conv_finish & ~finish_q`; a level held across layers is not a new event.
- States:
  - **IDLE:** if `run & ~abort`, go to SETTLE with `layer_idx`=0, `error`=0, `total_cycles`=0.
  - **SETTLE:** count `SETTLE_CYCLES` cycles, then go to START.
  - **START:** `conv_start`=1 for exactly this cycle, then go to WAIT. The watchdog counter is cleared here.
  - **WAIT:**
    - On a finish event with `layer_idx`==`NUM_LAYERS-1`, go to DONE.
    - On a finish event otherwise, increment `layer_idx` and go to SETTLE.
    - Finish events in other states are ignored.
  - **DONE:** `done`=1 and `busy`=0 for one cycle; `layer_idx` returns to 0; go to IDLE.
- `total_cycles` increments, saturating, every cycle `busy`=1. It holds its value in IDLE.
- `run` while busy is ignored. `run` is level-safe: a `run` held high restarts after DONE.
- `abort` in any non-IDLE state returns to IDLE the next cycle:
  - `conv_start`=0, `busy`=0, `layer_idx`=0;
  - no `done`;
  - `error` and `total_cycles` hold their values.
- Priority: `abort` over finish event over watchdog expiry; `abort` over `run` in IDLE.
- Deasserting `rst_n` mid-run forces all reset values immediately and asynchronously. No `done` is produced.

## Timing
- Cycle 0 is the cycle in which `run` is sampled high in IDLE. Let S=`SETTLE_CYCLES` and L=cycles from `conv_start` high to the finish edge being sampled (L≥1).
- `busy` rises in cycle 1. The first `conv_start` occurs in cycle S+1.
- Each later `conv_start` follows the previous one by L+S+1 cycles.
- `done` occurs in cycle N·(S+1+L)+1. `total_cycles` then equals N·(S+1+L).
- `layer_idx` changes only on the transition into SETTLE. It is therefore stable for ≥S cycles before `conv_start` and throughout WAIT.

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined:
  - A watchdog counter runs in WAIT.
  - Reaching `TIMEOUT_CYCLES` without a finish event sets `error`=1 and returns to IDLE the next cycle (`busy`=0, `layer_idx`=0, no `done`).
- Not defined:
  - No watchdog logic; WAIT persists indefinitely.
  - `error` is tied to 0.

## Test plan
- N=4, S=2, model with L=10, single `run` pulse → `conv_start` in cycles 3, 16, 29, 42; `layer_idx` 0,1,2,3; `done` in cycle 53; `total_cycles`=52.
- `conv_finish` held high as a level across layer boundaries, dropping only one cycle after each `conv_start` → exactly one advance per layer; no skipped layers.
- `abort` asserted in WAIT of layer 2, in the same cycle as a finish edge → IDLE next cycle; no `done`; `layer_idx`=0; `total_cycles` frozen.
- With `CONV_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, the model never finishes → `error`=1 twenty cycles after `conv_start`; `busy`=0; the next `run` clears `error`.
- `rst_n` pulsed low during SETTLE of layer 1 → all outputs 0 immediately; a subsequent `run` starts from layer 0.
- `run` pulsed during busy, then `run` held high → mid-run pulse ignored; held `run` starts a second run in the cycle after DONE.
